// File: rtl/obi_mem_bridge_pkg.sv
// Shared types and constants for the OBI-to-RAM bridge: response entry layout,
// stall LFSR polynomial and the LFSR bit masks that trigger grant/response stalls.
package obi_mem_bridge_pkg;

  typedef struct packed {
    logic [31:0] rdata;
    logic        err;
  } rsp_t;

  // Taps 16,14,13,11 map to state bits 15,13,12,10
  localparam logic [15:0] LFSR_TAPS      = 16'hB400;
  localparam logic [15:0] GNT_STALL_MASK = 16'h0003;
  localparam logic [15:0] RSP_STALL_MASK = 16'h000C;

  function automatic logic [15:0] lfsr_next(input logic [15:0] state);
    return {state[14:0], ^(state & LFSR_TAPS)};
  endfunction

endpackage

// File: rtl/obi_rsp_fifo.sv
// In-order response FIFO; simultaneous push and pop is allowed even when full,
// and the head entry is presented combinationally on pop_data.
module obi_rsp_fifo
  import obi_mem_bridge_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         push,
  input  rsp_t                         push_data,
  input  logic                         pop,
  output rsp_t                         pop_data,
  output logic                         full,
  output logic                         empty,
  output logic [$clog2(DEPTH+1)-1:0]   count
);

  localparam int unsigned CNT_W = $clog2(DEPTH + 1);
  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  rsp_t             mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             do_push;
  logic             do_pop;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] ptr);
    if (ptr == PTR_W'(DEPTH - 1)) begin
      return '0;
    end else begin
      return ptr + PTR_W'(1);
    end
  endfunction

  assign full     = (count == CNT_W'(DEPTH));
  assign empty    = (count == '0);
  assign do_pop   = pop & ~empty;
  assign do_push  = push & (~full | do_pop);
  assign pop_data = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= push_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= ptr_inc(wr_ptr);
      end
      if (do_pop) begin
        rd_ptr <= ptr_inc(rd_ptr);
      end
      case ({do_push, do_pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/obi_mem_bridge.sv
// OBI data-bus slave in front of a 1-cycle-latency RAM port: combinational grant,
// single-cycle RAM access, in-order registered responses with optional random stalls.
module obi_mem_bridge
  import obi_mem_bridge_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH      = 16,
  parameter logic [31:0] BASE_ADDR       = 32'h0000_0000,
  parameter int unsigned MAX_OUTSTANDING = 4,
  parameter bit          STALL_EN        = 1'b0,
  parameter logic [15:0] LFSR_SEED       = 16'hACE1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  data_req_i,
  output logic                  data_gnt_o,
  input  logic [31:0]           data_addr_i,
  input  logic                  data_we_i,
  input  logic [3:0]            data_be_i,
  input  logic [31:0]           data_wdata_i,
  output logic                  data_rvalid_o,
  output logic [31:0]           data_rdata_o,
  output logic                  data_err_o,
  output logic                  ram_en_o,
  output logic [ADDR_WIDTH-1:0] ram_addr_o,
  output logic                  ram_we_o,
  output logic [3:0]            ram_be_o,
  output logic [31:0]           ram_wdata_o,
  input  logic [31:0]           ram_rdata_i
);

  localparam int unsigned CNT_W = $clog2(MAX_OUTSTANDING + 1);

  logic [15:0]      lfsr;
  logic             gnt_stall;
  logic             rsp_stall;
  logic [CNT_W-1:0] outstanding;
  logic [31:0]      offset;
  logic             in_range;

  logic             pipe_valid;
  logic             pipe_read;
  logic             pipe_err;
  rsp_t             pipe_rsp;
  rsp_t             head_rsp;
  rsp_t             sel_rsp;

  logic             fifo_push;
  logic             fifo_pop;
  logic             fifo_full;
  logic             fifo_empty;
  logic [CNT_W-1:0] fifo_count;
  logic             rsp_fire;

  assign gnt_stall = STALL_EN && ((lfsr & GNT_STALL_MASK) == 16'h0000);
  assign rsp_stall = STALL_EN && ((lfsr & RSP_STALL_MASK) == 16'h0000);

  // Unsigned subtraction folds addresses below BASE_ADDR into the out-of-range case
  assign offset   = data_addr_i - BASE_ADDR;
  assign in_range = ((offset >> ADDR_WIDTH) == 32'd0);

  assign data_gnt_o  = ~rst & data_req_i & ~gnt_stall &
                       (outstanding < CNT_W'(MAX_OUTSTANDING));
  assign ram_en_o    = data_gnt_o & in_range;
  assign ram_addr_o  = offset[ADDR_WIDTH-1:0];
  assign ram_we_o    = data_we_i;
  assign ram_be_o    = data_be_i;
  assign ram_wdata_o = data_wdata_i;

  always_ff @(posedge clk) begin
    if (rst) begin
      lfsr <= LFSR_SEED;
    end else if (STALL_EN) begin
      lfsr <= lfsr_next(lfsr);
    end else begin
      lfsr <= lfsr;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pipe_valid <= 1'b0;
      pipe_read  <= 1'b0;
      pipe_err   <= 1'b0;
    end else begin
      pipe_valid <= data_gnt_o;
      pipe_read  <= ~data_we_i;
      pipe_err   <= ~in_range;
    end
  end

  // An empty FIFO lets the pipeline entry bypass straight to the response register,
  // which is what gives the gnt-to-rvalid latency of two cycles.
  always_comb begin
    pipe_rsp.rdata = (pipe_read & ~pipe_err) ? ram_rdata_i : 32'h0000_0000;
    pipe_rsp.err   = pipe_err;
    rsp_fire       = ((fifo_count != '0) | pipe_valid) & ~rsp_stall;
    sel_rsp        = fifo_empty ? pipe_rsp : head_rsp;
    fifo_pop       = rsp_fire & ~fifo_empty;
    fifo_push      = pipe_valid & ~(fifo_empty & rsp_fire) & (~fifo_full | fifo_pop);
  end

  obi_rsp_fifo #(
    .DEPTH (MAX_OUTSTANDING)
  ) u_rsp_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (fifo_push),
    .push_data (pipe_rsp),
    .pop       (fifo_pop),
    .pop_data  (head_rsp),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      data_rvalid_o <= 1'b0;
      data_rdata_o  <= 32'h0000_0000;
      data_err_o    <= 1'b0;
    end else begin
      data_rvalid_o <= rsp_fire;
      data_rdata_o  <= rsp_fire ? sel_rsp.rdata : 32'h0000_0000;
      data_err_o    <= rsp_fire & sel_rsp.err;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      outstanding <= '0;
    end else begin
      case ({data_gnt_o, data_rvalid_o})
        2'b10:   outstanding <= outstanding + CNT_W'(1);
        2'b01:   outstanding <= outstanding - CNT_W'(1);
        default: outstanding <= outstanding;
      endcase
    end
  end

endmodule

// File: tb/tb_obi_mem_bridge.sv
// Bench for obi_mem_bridge: a no-stall instance for directed cases and a stalling,
// MAX_OUTSTANDING=2 instance driven randomly, both scored against a transaction model.
module tb_obi_mem_bridge;

  localparam logic [31:0] BASE0 = 32'h0000_0000;
  localparam logic [31:0] BASE1 = 32'h0000_4000;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_total = 0;
  int n_bad   = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] want);
    n_total++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s: got=%0h want=%0h (t=%0t)", tag, got, want, $time);
    end
  endtask

  // ---------------- instance 0: no stalls, 64 KiB window at 0 ----------------
  logic        rst0 = 1'b1, req0 = 1'b0, we0 = 1'b0;
  logic [31:0] addr0 = 32'h0, wdata0 = 32'h0;
  logic [3:0]  be0 = 4'h0;
  logic        gnt0, rvalid0, err0, ram_en0, ram_we0;
  logic [31:0] rdata0, ram_wdata0, ram_rdata0;
  logic [15:0] ram_addr0;
  logic [3:0]  ram_be0;

  obi_mem_bridge #(
    .ADDR_WIDTH(16), .BASE_ADDR(BASE0), .MAX_OUTSTANDING(4), .STALL_EN(1'b0), .LFSR_SEED(16'hACE1)
  ) dut0 (
    .clk(clk), .rst(rst0), .data_req_i(req0), .data_gnt_o(gnt0), .data_addr_i(addr0),
    .data_we_i(we0), .data_be_i(be0), .data_wdata_i(wdata0), .data_rvalid_o(rvalid0),
    .data_rdata_o(rdata0), .data_err_o(err0), .ram_en_o(ram_en0), .ram_addr_o(ram_addr0),
    .ram_we_o(ram_we0), .ram_be_o(ram_be0), .ram_wdata_o(ram_wdata0), .ram_rdata_i(ram_rdata0)
  );

  // ---------------- instance 1: stalls, 256 B window at 0x4000 ----------------
  logic        rst1 = 1'b1, req1 = 1'b0, we1 = 1'b0;
  logic [31:0] addr1 = 32'h0, wdata1 = 32'h0;
  logic [3:0]  be1 = 4'h0;
  logic        gnt1, rvalid1, err1, ram_en1, ram_we1;
  logic [31:0] rdata1, ram_wdata1, ram_rdata1;
  logic [7:0]  ram_addr1;
  logic [3:0]  ram_be1;

  obi_mem_bridge #(
    .ADDR_WIDTH(8), .BASE_ADDR(BASE1), .MAX_OUTSTANDING(2), .STALL_EN(1'b1), .LFSR_SEED(16'hACE1)
  ) dut1 (
    .clk(clk), .rst(rst1), .data_req_i(req1), .data_gnt_o(gnt1), .data_addr_i(addr1),
    .data_we_i(we1), .data_be_i(be1), .data_wdata_i(wdata1), .data_rvalid_o(rvalid1),
    .data_rdata_o(rdata1), .data_err_o(err1), .ram_en_o(ram_en1), .ram_addr_o(ram_addr1),
    .ram_we_o(ram_we1), .ram_be_o(ram_be1), .ram_wdata_o(ram_wdata1), .ram_rdata_i(ram_rdata1)
  );

  // Dual-port RAM stand-ins: byte-enabled writes, registered read data
  logic [31:0] mem0 [16384];
  logic [31:0] mem1 [64];

  always @(posedge clk) begin
    if (ram_en0) begin
      if (ram_we0) begin
        for (int b = 0; b < 4; b++) if (ram_be0[b]) mem0[ram_addr0[15:2]][8*b +: 8] <= ram_wdata0[8*b +: 8];
      end else begin
        ram_rdata0 <= mem0[ram_addr0[15:2]];
      end
    end
  end

  always @(posedge clk) begin
    if (ram_en1) begin
      if (ram_we1) begin
        for (int b = 0; b < 4; b++) if (ram_be1[b]) mem1[ram_addr1[7:2]][8*b +: 8] <= ram_wdata1[8*b +: 8];
      end else begin
        ram_rdata1 <= mem1[ram_addr1[7:2]];
      end
    end
  end

  // ---------------- reference model ----------------
  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          gcyc;
  } exp_t;

  exp_t        q0[$];
  exp_t        q1[$];
  logic [31:0] mdl0 [int];
  logic [31:0] mdl1 [64];
  logic [31:0] last0_rdata = 32'h0;
  logic        last0_err = 1'b0;
  int          out1 = 0;
  int          gstall1 = 0;
  int          rstall1 = 0;

  function automatic logic [31:0] merge_be(input logic [31:0] old, input logic [31:0] d, input logic [3:0] be);
    logic [31:0] r;
    r = old;
    for (int b = 0; b < 4; b++) if (be[b]) r[8*b +: 8] = d[8*b +: 8];
    return r;
  endfunction

  always @(negedge clk) begin : mon0
    logic [31:0] off;
    logic [31:0] cur;
    exp_t        e;
    int          w;
    if (rst0) begin
      q0.delete();
    end else begin
      if (rvalid0) begin
        if (q0.size() == 0) begin
          check_eq("spurious_rvalid0", rvalid0, 1'b0);
        end else begin
          e = q0.pop_front();
          check_eq("rdata0", rdata0, e.rdata);
          check_eq("err0", err0, e.err);
          check_eq("latency0", cyc - e.gcyc, 2);
          last0_rdata = rdata0;
          last0_err   = err0;
        end
      end else begin
        check_eq("idle_rsp0", {err0, rdata0}, 33'h0);
      end
      if (req0 && gnt0) begin
        off    = addr0 - BASE0;
        e.gcyc = cyc;
        e.err  = !(64'(off) < (64'd1 << 16));
        e.rdata = 32'h0;
        check_eq("ram_en0", ram_en0, !e.err);
        if (!e.err) begin
          check_eq("ram_addr0", ram_addr0, off[15:0]);
          w   = int'(off >> 2);
          cur = mdl0.exists(w) ? mdl0[w] : 32'h0;
          if (we0) mdl0[w] = merge_be(cur, wdata0, be0);
          else     e.rdata = cur;
        end
        q0.push_back(e);
      end
    end
  end

  always @(negedge clk) begin : mon1
    logic [31:0] off;
    exp_t        e;
    if (rst1) begin
      q1.delete();
      out1 = 0;
    end else begin
      if (req1 && out1 >= 2) check_eq("gnt_at_max1", gnt1, 1'b0);
      if (req1 && !gnt1 && out1 < 2) gstall1++;
      if (!rvalid1 && q1.size() > 0 && q1[0].gcyc <= cyc - 2) rstall1++;
      if (rvalid1) begin
        if (q1.size() == 0) begin
          check_eq("spurious_rvalid1", rvalid1, 1'b0);
        end else begin
          e = q1.pop_front();
          check_eq("rdata1", rdata1, e.rdata);
          check_eq("err1", err1, e.err);
          check_eq("latency1_min", (cyc - e.gcyc) >= 2, 1'b1);
        end
      end else begin
        check_eq("idle_rsp1", {err1, rdata1}, 33'h0);
      end
      if (req1 && gnt1) begin
        off     = addr1 - BASE1;
        e.gcyc  = cyc;
        e.err   = !(64'(off) < (64'd1 << 8));
        e.rdata = 32'h0;
        check_eq("ram_en1", ram_en1, !e.err);
        if (!e.err) begin
          if (we1) mdl1[off[7:2]] = merge_be(mdl1[off[7:2]], wdata1, be1);
          else     e.rdata = mdl1[off[7:2]];
        end
        q1.push_back(e);
      end
      out1 = out1 + ((req1 && gnt1) ? 1 : 0) - (rvalid1 ? 1 : 0);
    end
  end

  // ---------------- drivers ----------------
  task automatic issue0(input logic [31:0] a, input logic w, input logic [3:0] b, input logic [31:0] d, output int waits);
    @(posedge clk); #1;
    req0 = 1'b1; addr0 = a; we0 = w; be0 = b; wdata0 = d;
    waits = 0;
    @(negedge clk);
    while (!gnt0 && waits < 50) begin waits++; @(negedge clk); end
    if (!gnt0) check_eq("gnt_timeout0", gnt0, 1'b1);
  endtask

  task automatic idle0();
    @(posedge clk); #1;
    req0 = 1'b0;
  endtask

  task automatic drain0();
    int n = 0;
    while (q0.size() != 0 && n < 100) begin @(negedge clk); n++; end
    check_eq("drain0", q0.size(), 0);
  endtask

  task automatic issue1(input logic [31:0] a, input logic w, input logic [3:0] b, input logic [31:0] d);
    int waits = 0;
    @(posedge clk); #1;
    req1 = 1'b1; addr1 = a; we1 = w; be1 = b; wdata1 = d;
    @(negedge clk);
    while (!gnt1 && waits < 100) begin waits++; @(negedge clk); end
    if (!gnt1) check_eq("gnt_timeout1", gnt1, 1'b1);
  endtask

  task automatic idle1();
    @(posedge clk); #1;
    req1 = 1'b0;
  endtask

  task automatic run0();
    int          w;
    int          g0;
    logic [31:0] d [8];
    req0 = 1'b1; addr0 = 32'h10; be0 = 4'hF;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_eq("rst_gnt0", gnt0, 1'b0);
    check_eq("rst_ram_en0", ram_en0, 1'b0);
    check_eq("rst_rvalid0", rvalid0, 1'b0);
    check_eq("rst_rsp0", {err0, rdata0}, 33'h0);
    @(posedge clk); #1;
    rst0 = 1'b0; req0 = 1'b0;

    issue0(32'h10, 1'b1, 4'hF, 32'h1234_5678, w);
    check_eq("gnt_same_cycle_wr", w, 0);
    issue0(32'h10, 1'b0, 4'hF, 32'h0, w);
    check_eq("gnt_same_cycle_rd", w, 0);
    idle0(); drain0();
    check_eq("basic_rdata", last0_rdata, 32'h1234_5678);
    check_eq("basic_err", last0_err, 1'b0);

    issue0(32'h20, 1'b1, 4'hF, 32'h0, w);
    issue0(32'h20, 1'b1, 4'b0010, 32'h0000_AB00, w);
    issue0(32'h20, 1'b0, 4'hF, 32'h0, w);
    idle0(); drain0();
    check_eq("partial_rdata", last0_rdata, 32'h0000_AB00);
    issue0(32'h23, 1'b1, 4'b1000, 32'h5A00_00FF, w);
    issue0(32'h20, 1'b0, 4'hF, 32'h0, w);
    idle0(); drain0();
    check_eq("partial_rdata2", last0_rdata, 32'h5A00_AB00);

    issue0(BASE0 + 32'h0001_0000, 1'b0, 4'hF, 32'h0, w);
    idle0(); drain0();
    check_eq("oor_err", last0_err, 1'b1);
    check_eq("oor_rdata", last0_rdata, 32'h0);

    for (int i = 0; i < 8; i++) begin
      d[i] = $urandom;
      issue0(32'h100 + 32'(i * 4), 1'b1, 4'hF, d[i], w);
    end
    for (int i = 0; i < 8; i++) begin
      issue0(32'h100 + 32'(i * 4), 1'b0, 4'hF, 32'h0, w);
      if (i == 0) g0 = cyc;
      else check_eq("b2b_gnt_cycle", cyc - g0, i);
    end
    idle0(); drain0();
    check_eq("b2b_last_rdata", last0_rdata, d[7]);

    for (int i = 0; i < 3; i++) issue0(32'h108 + 32'(i * 4), 1'b0, 4'hF, 32'h0, w);
    @(posedge clk); #1;
    req0 = 1'b0; rst0 = 1'b1;
    @(posedge clk); #1;
    rst0 = 1'b0;
    repeat (4) @(negedge clk);
    check_eq("post_rst_rvalid0", rvalid0, 1'b0);
    issue0(32'h104, 1'b0, 4'hF, 32'h0, w);
    check_eq("post_rst_gnt", w, 0);
    idle0(); drain0();
    check_eq("post_rst_rdata", last0_rdata, d[1]);
  endtask

  task automatic run1();
    logic [31:0] a;
    int          r;
    req1 = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_eq("rst_gnt1", gnt1, 1'b0);
    check_eq("rst_rvalid1", rvalid1, 1'b0);
    @(posedge clk); #1;
    rst1 = 1'b0; req1 = 1'b0;

    for (int i = 0; i < 64; i++) issue1(BASE1 + 32'(i * 4), 1'b1, 4'hF, $urandom);
    for (int i = 0; i < 1000; i++) begin
      r = $urandom_range(0, 9);
      if (r == 0)      a = BASE1 + 32'h100 + 32'($urandom_range(0, 1023));
      else if (r == 1) a = BASE1 - 32'($urandom_range(1, 64));
      else             a = BASE1 + 32'($urandom_range(0, 255));
      issue1(a, 1'($urandom_range(0, 1)), 4'($urandom), $urandom);
      if ($urandom_range(0, 3) == 0) idle1();
    end
    idle1();
    begin
      int n = 0;
      while (q1.size() != 0 && n < 200) begin @(negedge clk); n++; end
      check_eq("drain1", q1.size(), 0);
    end
    check_eq("gnt_stall_seen", gstall1 > 0, 1'b1);
    check_eq("rsp_stall_seen", rstall1 > 0, 1'b1);
  endtask

  initial begin
    #600000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1);
  end

  initial begin
    fork
      run0();
      run1();
    join
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule

// File: doc/obi_mem_bridge.md
Name: obi_mem_bridge

Overview:
- OBI-style data-bus slave sitting directly upstream of the testbench dual-port RAM.
- Converts core req/gnt/rvalid transactions into single-cycle RAM port-B accesses.
- Captures the RAM's 1-cycle registered read data and returns responses in order.
- Injects pseudo-random grant and response stalls, and flags out-of-range addresses with an error response.

Parameters:
- ADDR_WIDTH, 16: RAM byte-address width; the RAM window is 2**ADDR_WIDTH bytes.
- BASE_ADDR, 32'h0000_0000: byte address of RAM offset 0; must be aligned to 2**ADDR_WIDTH.
- MAX_OUTSTANDING, 4: maximum accepted-but-unanswered transactions, 1..8; also the response FIFO depth.
- STALL_EN, 0: 1 enables random gnt/rvalid stalls.
- LFSR_SEED, 16'hACE1: non-zero reset value of the stall LFSR.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- data_req_i  in  1  request valid
- data_gnt_o  out  1  request accepted this cycle
- data_addr_i  in  32  byte address
- data_we_i  in  1  1 = write
- data_be_i  in  4  byte enables
- data_wdata_i  in  32  write data
- data_rvalid_o  out  1  response valid (single-cycle pulse per transaction)
- data_rdata_o  out  32  read data
- data_err_o  out  1  error response
- ram_en_o  out  1  RAM port-B enable
- ram_addr_o  out  ADDR_WIDTH  RAM byte address
- ram_we_o  out  1  RAM write enable
- ram_be_o  out  4  RAM byte enables
- ram_wdata_o  out  32  RAM write data
- ram_rdata_i  in  32  RAM read data, valid the cycle after a read enable

Behaviour:
- Reset:
  - data_gnt_o, data_rvalid_o, data_err_o, ram_en_o = 0; data_rdata_o = 0.
  - Outstanding count = 0, FIFO empty, LFSR = LFSR_SEED.
  - Reset mid-operation drops all in-flight transactions; no rvalid is issued for them.
- Grant:
  - data_gnt_o = data_req_i & (outstanding < MAX_OUTSTANDING) & ~gnt_stall. This is combinational from req.
  - gnt_stall = STALL_EN & (lfsr[1:0] == 2'b00).
- Accept: when req & gnt in cycle T:
  - In range (addr - BASE_ADDR < 2**ADDR_WIDTH, unsigned):
    - ram_en_o = 1 in T; ram_addr_o = (addr - BASE_ADDR)[ADDR_WIDTH-1:0]; we/be/wdata pass through.
    - Low two address bits are passed through; the RAM word-aligns them.
  - Out of range: ram_en_o = 0; the transaction is tagged err.
  - ram_* outputs are only meaningful while ram_en_o = 1.
- Capture:
  - A 1-deep pipeline register records {valid, is_read, err} from T.
  - In T+1 one FIFO entry is pushed: rdata = ram_rdata_i for an in-range read, otherwise 0; err as tagged.
  - Writes push a response with rdata = 0, err = 0 (or err = 1 if out of range).
- Response:
  - When the FIFO is non-empty and ~rsp_stall, pop and drive data_rvalid_o = 1 with data_rdata_o/data_err_o from the entry, all registered.
  - rsp_stall = STALL_EN & (lfsr[3:2] == 2'b00).
  - Minimum latency: gnt at T, rvalid at T+2.
  - Strict in-order responses; exactly one rvalid per grant.
  - rdata and err are 0 whenever rvalid = 0.
- Outstanding counter:
  - +1 on grant, −1 on rvalid, unchanged when both occur in the same cycle.
  - Never exceeds MAX_OUTSTANDING, so the FIFO cannot overflow.
- FIFO: push and pop in the same cycle are permitted, including when the FIFO is full.
- LFSR:
  - 16-bit Fibonacci, taps 16,14,13,11; advances every cycle when STALL_EN = 1.
  - Frozen when STALL_EN = 0.
- Back-to-back: with STALL_EN = 0, one transaction is accepted per cycle. Steady-state throughput is 1/cycle.
- Request signals may change while gnt = 0; only the grant cycle is sampled.

Decomposition:
- obi_mem_bridge_pkg:
  - rsp_t struct {logic [31:0] rdata; logic err}
  - LFSR tap constant
  - GNT_STALL_MASK and RSP_STALL_MASK constants
- One sub-module, obi_rsp_fifo:
  - Parameterised depth, rsp_t entries.
  - push/pop/full/empty/count; synchronous active-high reset.

Test Plan:
- Write 32'h1234_5678 to 0x10 with be = 4'hF (STALL_EN = 0), then read 0x10. Required: gnt in the same cycle as req, rvalid 2 cycles after each gnt, rdata = 32'h1234_5678, err = 0.
- Partial write with be = 4'b0010, wdata = 32'h0000_AB00, to a word holding 0. Required: a subsequent read returns 32'h0000_AB00.
- Read from BASE_ADDR + 2**ADDR_WIDTH. Required: ram_en_o stays 0; rvalid with err = 1, rdata = 0.
- Eight back-to-back reads with req held and STALL_EN = 0. Required: 8 grants on consecutive cycles, 8 in-order rvalids on consecutive cycles, data matches preloaded memory.
- STALL_EN = 1, MAX_OUTSTANDING = 2, 1000 random transactions checked against a scoreboard. Required:
  - outstanding never exceeds 2 and gnt stays 0 while at 2
  - responses in order, data correct
  - grant and response stalls both occur at least once
- Reset asserted for 1 cycle with 3 transactions outstanding. Required: no rvalid afterwards for those transactions; next read completes at gnt+2 with correct data.
